// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolator sequencing controller.
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Right-shift amounts whose weighted sum approximates division by 50:
    // 1/64 + 1/256 + 1/2048 - 1/65536 ~= 0.02.
    localparam int STEP_SH_A = 6;
    localparam int STEP_SH_B = 8;
    localparam int STEP_SH_C = 11;
    localparam int STEP_SH_D = 16;

    // Fast-clock cycles per input sample and the phase of the frame boundary.
    // The step arithmetic above only holds for a ratio of 50.
    localparam int RATIO_DEFAULT      = 50;
    localparam int LOAD_PHASE_DEFAULT = 24;

endpackage

// File: rtl/interp_step_calc.sv
// Registered per-cycle increment: (v - v_prev) / 50 by shift-and-add.
module interp_step_calc
    import interp_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] v_prev,
    output logic signed [WIDTH-1:0] step_o
);

    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] step_d;
    logic signed [WIDTH-1:0] step_q;

    // Difference is one bit wider so any pair of samples subtracts exactly.
    always_comb begin
        diff   = {v[WIDTH-1], v} - {v_prev[WIDTH-1], v_prev};
        sum    = (diff >>> STEP_SH_A) + (diff >>> STEP_SH_B)
               + (diff >>> STEP_SH_C) - (diff >>> STEP_SH_D);
        step_d = sum[WIDTH-1:0];
    end

    // Step register follows v/v_prev by one cycle, so it moves right after ld_o.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/interp_sched.sv
// Sequencing controller: one-sample holding register, 1-in-RATIO frame
// boundary, interpolator load/step generation and underrun accounting.
module interp_sched
    import interp_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int RATIO      = RATIO_DEFAULT,
    parameter int LOAD_PHASE = LOAD_PHASE_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    s_valid,
    input  logic signed [WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic                    ld_o,
    output logic [WIDTH-1:0]        ld_val,
    output logic signed [WIDTH-1:0] step_o,
    output logic                    frame_o,
    output logic                    underrun_o,
    output logic [CNT_W-1:0]        underrun_cnt,
    input  logic                    clr_underrun
);

    localparam int              PH_W    = $clog2(RATIO);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(LOAD_PHASE);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(RATIO / 2);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]  v_q, v_d;
    logic [WIDTH-1:0]  v_prev_q, v_prev_d;
    logic              ld_q, ld_d;
    logic [WIDTH-1:0]  ld_val_q, ld_val_d;
    logic              frame_q, frame_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  underrun_cnt_q, underrun_cnt_d;
    logic              boundary;
    logic              consume;
    logic              underrun_evt;

    assign boundary = (phase_q == PH_LOAD) && (state_q != IDLE);
    assign s_ready  = !hold_full_q && (state_q != IDLE);

    // Next-state logic: boundary decisions use the pre-cycle hold contents,
    // so a sample written in the boundary cycle waits for the next frame.
    always_comb begin
        state_d        = state_q;
        hold_full_d    = hold_full_q;
        hold_d         = hold_q;
        v_d            = v_q;
        v_prev_d       = v_prev_q;
        ld_d           = 1'b0;
        ld_val_d       = ld_val_q;
        consume        = 1'b0;
        underrun_evt   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (boundary && hold_full_q) begin
                    v_d      = hold_q;
                    v_prev_d = hold_q;
                    ld_d     = 1'b1;
                    ld_val_d = hold_q;
                    consume  = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    ld_d     = 1'b1;
                    ld_val_d = v_q;
                    v_prev_d = v_q;
                    if (hold_full_q) begin
                        v_d     = hold_q;
                        consume = 1'b1;
                    end else begin
                        underrun_evt = 1'b1;
                    end
                    // Stopping freezes v so the step collapses to zero in IDLE.
                    if (!enable) begin
                        v_d     = v_q;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (s_valid && s_ready) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end else if (consume) begin
            hold_full_d = 1'b0;
        end
        if (state_d == IDLE) begin
            hold_full_d = 1'b0;
        end

        if ((state_q == IDLE) || (state_d == IDLE) || (phase_q == PH_LAST)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        frame_d = (state_d != IDLE) && (phase_d >= PH_HALF);

        underrun_d     = underrun_q;
        underrun_cnt_d = underrun_cnt_q;
        if (clr_underrun) begin
            underrun_d     = 1'b0;
            underrun_cnt_d = '0;
        end else if (underrun_evt) begin
            underrun_d = 1'b1;
            if (underrun_cnt_q != '1) begin
                underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            hold_full_q    <= 1'b0;
            hold_q         <= '0;
            v_q            <= '0;
            v_prev_q       <= '0;
            ld_q           <= 1'b0;
            ld_val_q       <= '0;
            frame_q        <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            hold_full_q    <= hold_full_d;
            hold_q         <= hold_d;
            v_q            <= v_d;
            v_prev_q       <= v_prev_d;
            ld_q           <= ld_d;
            ld_val_q       <= ld_val_d;
            frame_q        <= frame_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    interp_step_calc #(
        .WIDTH (WIDTH)
    ) u_step_calc (
        .clock  (clock),
        .reset  (reset),
        .v      (v_q),
        .v_prev (v_prev_q),
        .step_o (step_o)
    );

    assign ld_o         = ld_q;
    assign ld_val       = ld_val_q;
    assign frame_o      = frame_q;
    assign underrun_o   = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_interp_sched.sv
// Testbench for interp_sched: directed scenarios with hand-derived values
// followed by a randomized run checked against a behavioural model.
module tb_interp_sched;

    localparam int WIDTH      = 20;
    localparam int RATIO      = 50;
    localparam int LOAD_PHASE = 24;
    localparam int CNT_W      = 16;
    localparam int M_IDLE     = 0;
    localparam int M_PRIME    = 1;
    localparam int M_RUN      = 2;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             ld_o;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] step_o;
    logic             frame_o;
    logic             underrun_o;
    logic [CNT_W-1:0] underrun_cnt;
    logic             clr_underrun;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state: mode, cycles since leaving IDLE, hold as a queue.
    int m_mode  = M_IDLE;
    int m_age   = 0;
    int m_hold[$];
    int m_v     = 0;
    int m_vp    = 0;
    int m_step  = 0;
    int m_ldval = 0;
    int m_cnt   = 0;
    bit m_ld    = 0;
    bit m_frame = 0;
    bit m_ur    = 0;

    interp_sched #(
        .WIDTH      (WIDTH),
        .RATIO      (RATIO),
        .LOAD_PHASE (LOAD_PHASE),
        .CNT_W      (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .ld_o         (ld_o),
        .ld_val       (ld_val),
        .step_o       (step_o),
        .frame_o      (frame_o),
        .underrun_o   (underrun_o),
        .underrun_cnt (underrun_cnt),
        .clr_underrun (clr_underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Floor division, so the step is the exact sum of floored fractions of diff.
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int step_of(input int d);
        return fdiv(d, 64) + fdiv(d, 256) + fdiv(d, 2048) - fdiv(d, 65536);
    endfunction

    // Reference model, advanced on every rising edge from the applied inputs.
    always @(posedge clock) begin : model
        int nmode;
        int nv;
        int nvp;
        int phase;
        bit bnd;
        bit take;
        bit ur;
        if (reset) begin
            m_mode = M_IDLE; m_age = 0; m_hold.delete();
            m_v = 0; m_vp = 0; m_step = 0; m_ldval = 0; m_cnt = 0;
            m_ld = 0; m_frame = 0; m_ur = 0;
        end else begin
            phase = m_age % RATIO;
            bnd   = (m_mode != M_IDLE) && (phase == LOAD_PHASE);
            take  = s_valid && (m_hold.size() == 0) && (m_mode != M_IDLE);
            nmode = m_mode; nv = m_v; nvp = m_vp; ur = 0;
            m_step = step_of(m_v - m_vp);
            m_ld = 0;
            if (m_mode == M_IDLE) begin
                if (enable) nmode = M_PRIME;
            end else if (m_mode == M_PRIME) begin
                if (!enable) nmode = M_IDLE;
                else if (bnd && m_hold.size() != 0) begin
                    nv = m_hold[0]; nvp = m_hold[0];
                    m_ld = 1; m_ldval = m_hold[0];
                    void'(m_hold.pop_front());
                    nmode = M_RUN;
                end
            end else if (bnd) begin
                m_ld = 1; m_ldval = m_v; nvp = m_v;
                if (m_hold.size() != 0) begin
                    nv = m_hold[0];
                    void'(m_hold.pop_front());
                end else ur = 1;
                if (!enable) begin nv = m_v; nmode = M_IDLE; end
            end
            if (take) m_hold.push_back(int'($signed(s_data)));
            if (nmode == M_IDLE) m_hold.delete();
            m_age   = (m_mode == M_IDLE || nmode == M_IDLE) ? 0 : m_age + 1;
            m_frame = (nmode != M_IDLE) && ((m_age % RATIO) >= RATIO / 2);
            m_mode = nmode; m_v = nv; m_vp = nvp;
            if (clr_underrun) begin m_ur = 0; m_cnt = 0; end
            else if (ur) begin
                m_ur = 1;
                if (m_cnt != (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ld(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * RATIO; i++) begin
            tick();
            if (ld_o === 1'b1) begin seen = 1; break; end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s wait_ld: ld_o=0 for %0d cycles, expected a pulse", tag, 3 * RATIO);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * RATIO; i++) begin
            if (s_ready === 1'b1) begin seen = 1; break; end
            tick();
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s wait_ready: s_ready=0 for %0d cycles, expected 1", tag, 3 * RATIO);
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; s_valid = 0; s_data = '0; clr_underrun = 0;
        tick_n(2);
        vectors++;
        if ({s_ready, ld_o, ld_val, step_o, frame_o, underrun_o, underrun_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got rdy=%b ld=%b val=%0d step=%0d fr=%b ur=%b cnt=%0d, expected all 0",
                     s_ready, ld_o, ld_val, step_o, frame_o, underrun_o, underrun_cnt);
        end
        reset = 0;
        tick();
        vectors++;
        if (s_ready !== 1'b0 || frame_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle after reset: got rdy=%b frame=%b, expected 0 0", s_ready, frame_o);
        end
    endtask

    task automatic test_prime_no_samples();
        bit pulsed;
        pulsed = 0;
        enable = 1;
        for (int i = 0; i < 3 * RATIO + 10; i++) begin
            tick();
            if (ld_o !== 1'b0) pulsed = 1;
        end
        vectors++;
        if (pulsed) begin
            miscompares++;
            $display("[TB] FAIL prime_no_samples ld_o: got a pulse, expected none");
        end
        vectors++;
        if (underrun_cnt !== '0 || underrun_o !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL prime_no_samples status: got cnt=%0d ur=%b rdy=%b, expected 0 0 1",
                     underrun_cnt, underrun_o, s_ready);
        end
    endtask

    task automatic test_ramp(input int a, input int b, input int exp_step, input string tag);
        reset = 1; enable = 0; s_valid = 0;
        tick();
        reset = 0; enable = 1; s_valid = 1; s_data = WIDTH'(a);
        wait_ready(tag);
        tick();
        s_data = WIDTH'(b);
        wait_ld(tag);
        vectors++;
        if (ld_val !== WIDTH'(a) || step_o !== '0 || frame_o !== 1'b1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s first load: got val=%0d step=%0d fr=%b rdy=%b, expected %0d 0 1 1",
                     tag, $signed(ld_val), $signed(step_o), frame_o, s_ready, a);
        end
        tick();
        s_valid = 0;
        vectors++;
        if (step_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL %s step after first load: got %0d, expected 0", tag, $signed(step_o));
        end
        wait_ld(tag);
        vectors++;
        if (ld_val !== WIDTH'(a)) begin
            miscompares++;
            $display("[TB] FAIL %s second load ld_val: got %0d, expected %0d", tag, $signed(ld_val), a);
        end
        tick();
        vectors++;
        if (step_o !== WIDTH'(exp_step)) begin
            miscompares++;
            $display("[TB] FAIL %s step: got %0d, expected %0d", tag, $signed(step_o), exp_step);
        end
    endtask

    // Continues from the 1000 -> 2000 ramp: v=2000, hold empty.
    task automatic test_underrun();
        wait_ld("underrun1");
        vectors++;
        if (ld_val !== WIDTH'(2000) || underrun_o !== 1'b1 || underrun_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL underrun1: got val=%0d ur=%b cnt=%0d, expected 2000 1 1",
                     $signed(ld_val), underrun_o, underrun_cnt);
        end
        wait_ld("underrun2");
        vectors++;
        if (ld_val !== WIDTH'(2000) || underrun_cnt !== CNT_W'(2)) begin
            miscompares++;
            $display("[TB] FAIL underrun2: got val=%0d cnt=%0d, expected 2000 2", $signed(ld_val), underrun_cnt);
        end
        tick();
        vectors++;
        if (step_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL underrun step: got %0d, expected 0", $signed(step_o));
        end
        clr_underrun = 1;
        tick();
        clr_underrun = 0;
        vectors++;
        if (underrun_o !== 1'b0 || underrun_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL clear: got ur=%b cnt=%0d, expected 0 0", underrun_o, underrun_cnt);
        end
        tick_n(47);
        clr_underrun = 1;
        tick();
        clr_underrun = 0;
        vectors++;
        if (ld_o !== 1'b1 || underrun_o !== 1'b0 || underrun_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: got ld=%b ur=%b cnt=%0d, expected 1 0 0", ld_o, underrun_o, underrun_cnt);
        end
    endtask

    // Starts in a load cycle (phase 25) with hold empty and v=2000.
    task automatic test_boundary_write();
        bit rdy_seen;
        rdy_seen = 0;
        tick_n(RATIO - 1);
        s_valid = 1; s_data = WIDTH'(3000);
        tick();
        s_valid = 0;
        vectors++;
        if (ld_o !== 1'b1 || ld_val !== WIDTH'(2000) || underrun_cnt !== CNT_W'(1) || s_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL boundary_write load: got ld=%b val=%0d cnt=%0d rdy=%b, expected 1 2000 1 0",
                     ld_o, $signed(ld_val), underrun_cnt, s_ready);
        end
        for (int i = 0; i < RATIO - 1; i++) begin
            tick();
            if (s_ready !== 1'b0) rdy_seen = 1;
        end
        vectors++;
        if (rdy_seen) begin
            miscompares++;
            $display("[TB] FAIL boundary_write s_ready: got 1 before next boundary, expected 0");
        end
        tick();
        vectors++;
        if (ld_o !== 1'b1 || ld_val !== WIDTH'(2000) || s_ready !== 1'b1 || underrun_cnt !== CNT_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL boundary_write next load: got ld=%b val=%0d rdy=%b cnt=%0d, expected 1 2000 1 1",
                     ld_o, $signed(ld_val), s_ready, underrun_cnt);
        end
        tick();
        vectors++;
        if (step_o !== WIDTH'(18)) begin
            miscompares++;
            $display("[TB] FAIL boundary_write step: got %0d, expected 18", $signed(step_o));
        end
    endtask

    // Starts at phase 26 with v=3000, hold empty.
    task automatic test_enable_drop();
        bit pulsed;
        pulsed = 0;
        s_valid = 1; s_data = WIDTH'(5000);
        tick();
        s_valid = 0;
        tick_n(33);
        enable = 0;
        tick_n(14);
        tick();
        vectors++;
        if (ld_o !== 1'b1 || ld_val !== WIDTH'(3000) || s_ready !== 1'b0 || frame_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL enable_drop load: got ld=%b val=%0d rdy=%b fr=%b, expected 1 3000 0 0",
                     ld_o, $signed(ld_val), s_ready, frame_o);
        end
        tick();
        vectors++;
        if (step_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL enable_drop step: got %0d, expected 0", $signed(step_o));
        end
        for (int i = 0; i < 2 * RATIO; i++) begin
            tick();
            if (ld_o !== 1'b0 || frame_o !== 1'b0 || s_ready !== 1'b0) pulsed = 1;
        end
        vectors++;
        if (pulsed) begin
            miscompares++;
            $display("[TB] FAIL enable_drop idle: got activity after stop, expected ld/frame/ready all 0");
        end
    endtask

    task automatic test_reset_mid();
        reset = 1; enable = 0; s_valid = 0;
        tick();
        reset = 0; enable = 1; s_valid = 1; s_data = WIDTH'(100);
        wait_ready("reset_mid");
        tick();
        s_valid = 0;
        wait_ld("reset_mid prime");
        wait_ld("reset_mid underrun");
        tick_n(5);
        vectors++;
        if (underrun_o !== 1'b1 || frame_o !== 1'b1 || ld_val !== WIDTH'(100)) begin
            miscompares++;
            $display("[TB] FAIL reset_mid before: got ur=%b fr=%b val=%0d, expected 1 1 100",
                     underrun_o, frame_o, $signed(ld_val));
        end
        reset = 1;
        tick();
        vectors++;
        if ({s_ready, ld_o, ld_val, step_o, frame_o, underrun_o, underrun_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid outputs: got rdy=%b ld=%b val=%0d step=%0d fr=%b ur=%b cnt=%0d, expected all 0",
                     s_ready, ld_o, ld_val, step_o, frame_o, underrun_o, underrun_cnt);
        end
        reset = 0;
    endtask

    task automatic test_random();
        bit will_xfer;
        bit exp_ready;
        will_xfer = 0;
        reset = 1; enable = 0; s_valid = 0; clr_underrun = 0;
        tick();
        reset = 0; enable = 1;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(299) == 0) enable = !enable;
            clr_underrun = ($urandom_range(79) == 0);
            reset = ($urandom_range(1999) == 0);
            if (!s_valid || will_xfer) begin
                s_valid = ($urandom_range(24) == 0);
                s_data  = WIDTH'($urandom);
            end
            will_xfer = s_valid && !reset && (m_hold.size() == 0) && (m_mode != M_IDLE);
            tick();
            exp_ready = (m_hold.size() == 0) && (m_mode != M_IDLE);
            vectors++;
            if (s_ready !== exp_ready || ld_o !== m_ld || (m_ld && ld_val !== WIDTH'(m_ldval)) ||
                step_o !== WIDTH'(m_step) || frame_o !== m_frame || underrun_o !== m_ur ||
                underrun_cnt !== CNT_W'(m_cnt)) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d: got rdy=%b ld=%b val=%0d step=%0d fr=%b ur=%b cnt=%0d, expected rdy=%b ld=%b val=%0d step=%0d fr=%b ur=%b cnt=%0d",
                         c, s_ready, ld_o, $signed(ld_val), $signed(step_o), frame_o, underrun_o, underrun_cnt,
                         exp_ready, m_ld, m_ldval, m_step, m_frame, m_ur, m_cnt);
            end
        end
        reset = 0; clr_underrun = 0; s_valid = 0;
    endtask

    initial begin
        reset = 1; enable = 0; s_valid = 0; s_data = '0; clr_underrun = 0;
        test_reset();
        test_prime_no_samples();
        test_ramp(2000, 1000, -20, "ramp_down");
        test_ramp(1000, 2000, 18, "ramp_up");
        test_underrun();
        test_boundary_write();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
